// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART byte receiver feeding a short/long command decoder.
// A short command is one byte with bit7 clear. A long command is an opcode byte
// with bit7 set, followed by four little-endian argument bytes.
module serial_receiver #(
  parameter int unsigned FREQ    = 100000000,
  parameter int unsigned RATE    = 115200,
  parameter int unsigned TIMEOUT = 10000000
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic        rx,
  output logic [7:0]  opcode,
  output logic [31:0] parameter_value,
  output logic        execute,
  output logic        framing_error
);

  localparam int unsigned BIT_LEN  = FREQ / RATE;
  localparam int unsigned HALF_LEN = BIT_LEN / 2;
  localparam int unsigned CNT_W    = ($clog2(BIT_LEN + 1) > 10) ? $clog2(BIT_LEN + 1) : 10;
  localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_WAIT_HIGH
  } bit_state_t;

  typedef enum logic {
    CMD_OP,
    CMD_PARAM
  } cmd_state_t;

  // synchronizer
  logic rx_meta;
  logic rx_s;

  // bit-level receiver
  bit_state_t       bit_state;
  bit_state_t       bit_state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       rx_byte;
  logic [7:0]       rx_byte_next;
  logic             byte_strobe_c;
  logic             frame_err_c;

  // command decoder
  cmd_state_t       cmd_state;
  cmd_state_t       cmd_state_next;
  logic [1:0]       param_cnt;
  logic [1:0]       param_cnt_next;
  logic [31:0]      param_buf;
  logic [31:0]      param_buf_next;
  logic [7:0]       pend_op;
  logic [7:0]       pend_op_next;
  logic [TO_W-1:0]  idle_cnt;
  logic [TO_W-1:0]  idle_cnt_next;
  logic [7:0]       opcode_next;
  logic [31:0]      param_next;
  logic             execute_next;

  // Two-flop synchronizer on the asynchronous line; resets to the idle level.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      bit_state <= BIT_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
    end else begin
      bit_state <= bit_state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      rx_byte   <= rx_byte_next;
    end
  end

  // Bit FSM next state: mid-start check, then one sample per bit period.
  always_comb begin
    bit_state_next = bit_state;
    bit_cnt_next   = bit_cnt + 1'b1;
    bit_idx_next   = bit_idx;
    rx_byte_next   = rx_byte;
    unique case (bit_state)
      BIT_IDLE: begin
        bit_cnt_next = '0;
        if (!rx_s) begin
          bit_state_next = BIT_START;
        end
      end
      BIT_START: begin
        if (bit_cnt == HALF_LAST) begin
          bit_cnt_next   = '0;
          bit_idx_next   = '0;
          bit_state_next = rx_s ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next          = '0;
          rx_byte_next[bit_idx] = rx_s;
          bit_idx_next          = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            bit_state_next = BIT_STOP;
          end
        end
      end
      BIT_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next   = '0;
          bit_state_next = rx_s ? BIT_IDLE : BIT_WAIT_HIGH;
        end
      end
      BIT_WAIT_HIGH: begin
        // a held-low line (break) reports once, then waits for idle
        bit_cnt_next = '0;
        if (rx_s) begin
          bit_state_next = BIT_IDLE;
        end
      end
      default: begin
        bit_state_next = BIT_IDLE;
        bit_cnt_next   = '0;
      end
    endcase
  end

  // Bit FSM outputs: stop-bit verdict, valid for the single sampling cycle.
  always_comb begin
    byte_strobe_c = 1'b0;
    frame_err_c   = 1'b0;
    if ((bit_state == BIT_STOP) && (bit_cnt == BIT_LAST)) begin
      byte_strobe_c = rx_s;
      frame_err_c   = !rx_s;
    end
  end

  // Registered framing error pulse, aligned with where execute would appear.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      framing_error <= 1'b0;
    end else begin
      framing_error <= frame_err_c;
    end
  end

  // Command FSM state register.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      cmd_state <= CMD_OP;
      param_cnt <= '0;
      param_buf <= '0;
      pend_op   <= '0;
      idle_cnt  <= '0;
    end else begin
      cmd_state <= cmd_state_next;
      param_cnt <= param_cnt_next;
      param_buf <= param_buf_next;
      pend_op   <= pend_op_next;
      idle_cnt  <= idle_cnt_next;
    end
  end

  // Command FSM next state: collect argument bytes, abort on error or idle timeout.
  always_comb begin
    cmd_state_next = cmd_state;
    param_cnt_next = param_cnt;
    param_buf_next = param_buf;
    pend_op_next   = pend_op;
    idle_cnt_next  = '0;
    unique case (cmd_state)
      CMD_OP: begin
        if (byte_strobe_c && rx_byte[7]) begin
          pend_op_next   = rx_byte;
          param_cnt_next = '0;
          param_buf_next = '0;
          cmd_state_next = CMD_PARAM;
        end
      end
      CMD_PARAM: begin
        if (byte_strobe_c) begin
          param_buf_next[{param_cnt, 3'b000} +: 8] = rx_byte;
          param_cnt_next = param_cnt + 1'b1;
          if (param_cnt == 2'd3) begin
            cmd_state_next = CMD_OP;
          end
        end else if (frame_err_c) begin
          cmd_state_next = CMD_OP;
        end else if (idle_cnt == TO_LAST) begin
          cmd_state_next = CMD_OP;
        end else begin
          idle_cnt_next = idle_cnt + 1'b1;
        end
      end
      default: begin
        cmd_state_next = CMD_OP;
      end
    endcase
  end

  // Command FSM outputs: values loaded into the output registers on completion.
  always_comb begin
    opcode_next  = opcode;
    param_next   = parameter_value;
    execute_next = 1'b0;
    if (byte_strobe_c) begin
      if ((cmd_state == CMD_OP) && !rx_byte[7]) begin
        opcode_next  = rx_byte;
        param_next   = '0;
        execute_next = 1'b1;
      end else if ((cmd_state == CMD_PARAM) && (param_cnt == 2'd3)) begin
        opcode_next  = pend_op;
        param_next   = {rx_byte, param_buf[23:0]};
        execute_next = 1'b1;
      end
    end
  end

  // Command output registers; opcode and argument change only with execute.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      opcode          <= '0;
      parameter_value <= '0;
      execute         <= 1'b0;
    end else begin
      opcode          <= opcode_next;
      parameter_value <= param_next;
      execute         <= execute_next;
    end
  end

endmodule
